// File: rtl/uart_pkg.sv
// Shared UART definitions used by the TX framer and the RX blocks.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int UART_DATA_WIDTH     = 8;
    localparam int UART_PRESCALE_WIDTH = 6;

endpackage

// File: rtl/uart_tx_frame_if.sv
// Parallel-side handshake and serial output of the UART transmit framer.
interface uart_tx_frame_if
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = UART_DATA_WIDTH,
    parameter int PRESCALE_WIDTH = UART_PRESCALE_WIDTH
);
    logic [DATA_WIDTH-1:0]     P_DATA;
    logic                      Data_Valid;
    logic                      PAR_EN;
    logic                      PAR_TYP;
    logic [PRESCALE_WIDTH-1:0] Prescale;
    logic                      TX_OUT;
    logic                      Busy;

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
        input  TX_OUT, Busy
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
        output TX_OUT, Busy
    );
endinterface

// File: rtl/uart_parity_calc.sv
// Combinational parity bit; shared by TX framing and RX checking so both ends agree.
module uart_parity_calc
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  parity
);
    assign parity = (^data) ^ (par_typ == PAR_ODD);
endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start, DATA_WIDTH bits LSB first, optional parity, stop.
// state  | meaning
// IDLE   | line high, waiting for Data_Valid
// START  | start bit (0)
// DATA   | data bits, LSB first
// PARITY | parity bit (only when PAR_EN latched)
// STOP   | stop bit (1), then back to IDLE
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = UART_DATA_WIDTH,
    parameter int PRESCALE_WIDTH = UART_PRESCALE_WIDTH
) (
    input  logic            CLK,
    input  logic            RST,
    uart_tx_frame_if.slave  tx_if
);
    localparam int IDX_WIDTH = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_WIDTH-1:0]      LAST_IDX = IDX_WIDTH'(DATA_WIDTH - 1);
    localparam logic [PRESCALE_WIDTH-1:0] ONE      = PRESCALE_WIDTH'(1);

    uart_state_e               state;
    logic [PRESCALE_WIDTH-1:0] bit_cnt;
    logic [PRESCALE_WIDTH-1:0] prescale_l;
    logic [DATA_WIDTH-1:0]     data_l;
    logic [DATA_WIDTH-1:0]     shift_q;
    logic [IDX_WIDTH-1:0]      bit_idx;
    logic                      par_en_l;
    logic                      par_typ_l;
    logic                      tx_out_q;
    logic                      busy_q;
    logic                      par_bit;
    logic                      bit_done;

    uart_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
        .data    (data_l),
        .par_typ (par_typ_l),
        .parity  (par_bit)
    );

    // Prescale=0 makes the compare value all-ones, giving a full 2^N-cycle bit.
    assign bit_done = (bit_cnt == prescale_l - ONE);

    assign tx_if.TX_OUT = tx_out_q;
    assign tx_if.Busy   = busy_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            tx_out_q   <= 1'b1;
            busy_q     <= 1'b0;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            prescale_l <= '0;
            data_l     <= '0;
            shift_q    <= '0;
            par_en_l   <= 1'b0;
            par_typ_l  <= PAR_EVEN;
        end else begin
            if (state != IDLE) begin
                bit_cnt <= bit_done ? '0 : bit_cnt + ONE;
            end
            case (state)
                IDLE: begin
                    if (tx_if.Data_Valid) begin
                        data_l     <= tx_if.P_DATA;
                        shift_q    <= tx_if.P_DATA;
                        par_en_l   <= tx_if.PAR_EN;
                        par_typ_l  <= tx_if.PAR_TYP;
                        prescale_l <= tx_if.Prescale;
                        bit_cnt    <= '0;
                        state      <= START;
                        tx_out_q   <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                START: begin
                    if (bit_done) begin
                        state    <= DATA;
                        bit_idx  <= '0;
                        tx_out_q <= shift_q[0];
                        shift_q  <= shift_q >> 1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        if (bit_idx == LAST_IDX) begin
                            if (par_en_l) begin
                                state    <= PARITY;
                                tx_out_q <= par_bit;
                            end else begin
                                state    <= STOP;
                                tx_out_q <= 1'b1;
                            end
                        end else begin
                            bit_idx  <= bit_idx + 1'b1;
                            tx_out_q <= shift_q[0];
                            shift_q  <= shift_q >> 1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_done) begin
                        state    <= STOP;
                        tx_out_q <= 1'b1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        state    <= IDLE;
                        tx_out_q <= 1'b1;
                        busy_q   <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    tx_out_q <= 1'b1;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Transmit-side UART framer, the counterpart of the receive path's data sampling and deserialisation. It accepts a parallel byte on a valid strobe and serialises it on TX_OUT as start bit, data bits LSB first, an optional parity bit, then a stop bit. Each bit is held for Prescale clock cycles, so TX runs on the same oversampled clock and Prescale setting as RX.

Parameters:
DATA_WIDTH, 8, number of data bits per frame
PRESCALE_WIDTH, 6, width of the Prescale input and of the bit-period counter

Ports:
CLK  input  1  system clock; all logic is on the rising edge
RST  input  1  synchronous reset, active-high
P_DATA  input  DATA_WIDTH  parallel byte to transmit
Data_Valid  input  1  P_DATA valid; accepted only while Busy=0
PAR_EN  input  1  1 = append a parity bit
PAR_TYP  input  1  0 = even parity, 1 = odd parity
Prescale  input  PRESCALE_WIDTH  clock cycles per bit (8/16/32 nominal)
TX_OUT  output  1  serial line output (registered)
Busy  output  1  frame in progress (registered)

Behaviour:
- Reset (RST=1 at a rising edge): TX_OUT=1, Busy=0, state=IDLE, counters=0. This holds from that edge onward, including mid-frame; an abandoned frame is not resumed.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX_OUT=1, Busy=0. If Data_Valid=1 at edge n:
  - latch P_DATA, PAR_EN, PAR_TYP and Prescale into shadow registers;
  - go to START; from edge n, TX_OUT=0 and Busy=1 (one-cycle latency).
- Inputs are sampled only at acceptance. Changes to P_DATA, PAR_EN, PAR_TYP or Prescale during a frame have no effect.
- Bit timer: counts 0..Prescale_latched-1. A bit ends when the count reaches Prescale_latched-1; the count then wraps to 0 and the next bit begins.
  - Prescale=0 gives a period of 64 (natural 6-bit wrap).
  - Prescale=1 gives one cycle per bit.
- START: hold TX_OUT=0 for one bit period, then go to DATA.
- DATA: drive bit index 0..DATA_WIDTH-1 in order, one bit period each, LSB first. After the last bit, go to PARITY if PAR_EN_latched=1, else to STOP.
- PARITY: TX_OUT = XOR-reduction of the latched data, inverted when PAR_TYP_latched=1. One bit period, then STOP.
- STOP: TX_OUT=1 for one bit period, then IDLE. TX_OUT stays 1 and Busy falls at that edge.
- Frame length: (2 + DATA_WIDTH + PAR_EN) × Prescale cycles, with Busy=1 for exactly this many cycles.
- Back-to-back frames: IDLE always lasts at least one cycle, so with Data_Valid held high the inter-frame gap is exactly 1 cycle of TX_OUT=1.
- Data_Valid while Busy=1 is ignored; there is no queuing and no error flag.
- RST and Data_Valid at the same edge: reset wins and nothing is accepted.
- TX_OUT and Busy are flop outputs with no combinational path from any input.

Decomposition:
- Shared package uart_pkg holds:
  - the state enumeration (IDLE, START, DATA, PARITY, STOP);
  - constants PAR_EVEN=0 and PAR_ODD=1;
  - the default DATA_WIDTH and PRESCALE_WIDTH, shared with the RX blocks.
- One natural sub-module, uart_parity_calc: combinational parity from the latched data plus PAR_TYP. It is reused by the RX parity checker so both ends compute parity identically.
- The FSM, bit timer and bit-index counter stay in uart_tx_frame.

Test Plan:
- Basic frame: Prescale=8, PAR_EN=1, PAR_TYP=0, P_DATA=0xA5, one-cycle Data_Valid → TX_OUT = 0, then 1,0,1,0,0,1,0,1, parity 0, stop 1, each held 8 cycles. Busy=1 for exactly 88 cycles; TX_OUT falls the cycle after acceptance.
- Odd parity: Prescale=16, PAR_TYP=1, P_DATA=0x01 → parity bit 0. Repeat with PAR_TYP=0 → parity bit 1. Each frame is 176 cycles.
- No parity: PAR_EN=0, Prescale=32, P_DATA=0xFF → start, 8 ones, stop. Busy=1 for 320 cycles, with no parity slot.
- Ignored and mid-frame inputs: during a frame of 0x3C, pulse Data_Valid with P_DATA=0x00 and change Prescale/PAR_EN → the 0x3C frame is unchanged, no second frame follows, Busy falls once.
- Back-to-back: Data_Valid held high with 0x55 then 0xAA, Prescale=8 → two complete frames separated by exactly one cycle of TX_OUT=1 and Busy=0.
- Reset mid-frame: assert RST for one cycle during data bit 3 → at that edge TX_OUT=1, Busy=0. After reset releases, a new Data_Valid produces a correct full frame.
